// File: rtl/fc_port_state.sv
// Fibre Channel primary port state machine: ordered-set recognition, R_T_TOV timer, state output.
// Optional FC_PORT_STATE_STATS_EN adds saturating link failure / recovery counters.
package fc;
  typedef enum logic [3:0] {
    STATE_OL1, STATE_OL2, STATE_OL3, STATE_AC,
    STATE_LR1, STATE_LR2, STATE_LR3, STATE_LF1, STATE_LF2
  } state_t;

  typedef enum logic [2:0] {
    OS_NONE, OS_OLS, OS_NOS, OS_LR, OS_LRR, OS_IDLE
  } os_t;

  localparam logic [31:0] IDLE  = 32'hBC95_B5B5;
  localparam logic [31:0] ARBFF = 32'hBC94_9F9F;
  localparam logic [31:0] NOS   = 32'hBC55_BF45;
  localparam logic [31:0] OLS   = 32'hBC35_8A55;
  localparam logic [31:0] LR    = 32'hBC49_BF49;
  localparam logic [31:0] LRR   = 32'hBC35_BF49;
endpackage

module fc_port_state #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic        rx_valid,
  input  logic        rx_sync,
  input  logic        offline_req,
  input  logic        link_reset_req,
`ifdef FC_PORT_STATE_STATS_EN
  input  logic        stats_clear,
  output logic [15:0] link_failures,
  output logic [15:0] link_recoveries,
`endif
  output fc::state_t  state,
  output logic        active,
  output logic        state_change
);
  import fc::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  os_t           os_kind;
  os_t           run_kind;
  logic [1:0]    run_cnt;
  logic          run_same;
  logic          seq_valid;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          seq_hit;
  state_t        seq_next;
  state_t        next_state;

  // Classify the current word
  always_comb begin
    os_kind = OS_NONE;
    if (rx_datak == 4'b1000) begin
      case (rx_data)
        OLS:         os_kind = OS_OLS;
        NOS:         os_kind = OS_NOS;
        LR:          os_kind = OS_LR;
        LRR:         os_kind = OS_LRR;
        IDLE, ARBFF: os_kind = OS_IDLE;
        default:     os_kind = OS_NONE;
      endcase
    end
  end

  // Recognition is taken from the incoming word so the state moves on the edge sampling the 3rd match
  assign run_same  = (os_kind != OS_NONE) && (os_kind == run_kind) && (run_cnt != 2'd0);
  assign seq_valid = rx_sync && rx_valid && run_same && (run_cnt >= 2'd2);

  // Run counter: invalid cycles hold the run, any non-ordered-set word breaks it
  always_ff @(posedge clk) begin
    if (reset || !rx_sync) begin
      run_cnt  <= 2'd0;
      run_kind <= OS_NONE;
    end else if (rx_valid) begin
      if (os_kind == OS_NONE) begin
        run_cnt  <= 2'd0;
        run_kind <= OS_NONE;
      end else if (run_same) begin
        if (run_cnt != 2'd3) run_cnt <= run_cnt + 2'd1;
      end else begin
        run_cnt  <= 2'd1;
        run_kind <= os_kind;
      end
    end
  end

  assign timeout = (state inside {STATE_LR1, STATE_LR2, STATE_LR3}) && (timer == TIMER_LAST);

  // R_T_TOV timer; a timeout always leaves the LR states, so it never wraps
  always_ff @(posedge clk) begin
    if (reset || (next_state != state)) begin
      timer <= '0;
    end else if (state inside {STATE_LR1, STATE_LR2, STATE_LR3}) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= STATE_OL1;
      active       <= 1'b0;
      state_change <= 1'b0;
    end else begin
      state        <= next_state;
      active       <= (next_state == STATE_AC);
      state_change <= (next_state != state);
    end
  end

  // Next state; a sequence only wins over lower priorities when it has a transition here
  always_comb begin
    next_state = state;
    seq_next   = state;
    if (seq_valid) begin
      case (state)
        STATE_OL1: if (os_kind == OS_OLS) seq_next = STATE_OL2;
                   else if (os_kind == OS_LR) seq_next = STATE_LR2;
        STATE_OL2: if (os_kind == OS_LR) seq_next = STATE_LR2;
                   else if (os_kind == OS_NOS) seq_next = STATE_LF1;
        STATE_AC:  if (os_kind == OS_LR) seq_next = STATE_LR2;
                   else if (os_kind == OS_LRR) seq_next = STATE_LR3;
                   else if (os_kind == OS_OLS) seq_next = STATE_OL2;
                   else if (os_kind == OS_NOS) seq_next = STATE_LF1;
        STATE_LR1: if (os_kind == OS_LRR) seq_next = STATE_LR3;
                   else if (os_kind == OS_LR) seq_next = STATE_LR2;
        STATE_LR2: if (os_kind == OS_LRR) seq_next = STATE_LR3;
                   else if (os_kind == OS_IDLE) seq_next = STATE_AC;
        STATE_LR3: if (os_kind == OS_IDLE) seq_next = STATE_AC;
                   else if (os_kind == OS_LR) seq_next = STATE_LR2;
        STATE_LF1: if (os_kind == OS_OLS) seq_next = STATE_OL2;
                   else if (os_kind == OS_LR) seq_next = STATE_LR2;
        STATE_LF2: if (os_kind == OS_NOS) seq_next = STATE_LF1;
                   else if (os_kind == OS_OLS) seq_next = STATE_OL2;
                   else if (os_kind == OS_LR) seq_next = STATE_LR2;
        default:   seq_next = state;
      endcase
    end
    seq_hit = (seq_next != state);

    if (!rx_sync && !(state inside {STATE_OL1, STATE_OL2, STATE_OL3, STATE_LF2})) begin
      next_state = STATE_LF2;
    end else if (offline_req && (state != STATE_OL3)) begin
      next_state = STATE_OL3;
    end else if ((state == STATE_OL3) && !offline_req) begin
      next_state = STATE_OL1;
    end else if (seq_hit) begin
      next_state = seq_next;
    end else if (timeout) begin
      next_state = STATE_LF2;
    end else if (link_reset_req && (state == STATE_AC)) begin
      next_state = STATE_LR1;
    end
  end

`ifdef FC_PORT_STATE_STATS_EN
  logic fail_entry;
  logic rec_entry;

  assign fail_entry = (next_state != state) && (next_state inside {STATE_LF1, STATE_LF2});
  assign rec_entry  = (next_state != state) && (next_state inside {STATE_LR1, STATE_LR2});

  // Saturating counters; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      link_failures   <= 16'd0;
      link_recoveries <= 16'd0;
    end else begin
      if (fail_entry && (link_failures != 16'hFFFF)) link_failures <= link_failures + 16'd1;
      if (rec_entry && (link_recoveries != 16'hFFFF)) link_recoveries <= link_recoveries + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fc_port_state.sv
// Self-checking bench for fc_port_state: directed table, hand sequences, random run against a model.
module tb_fc_port_state;
  import fc::*;

  localparam int unsigned T = 4;
  localparam logic [31:0] FILL = 32'h4A4A_4A4A;
  localparam logic [31:0] GAPW = 32'hDEAD_BEEF;
  localparam int K_NONE = 0, K_OLS = 1, K_NOS = 2, K_LR = 3, K_LRR = 4, K_IDLE = 5;

  logic        clk;
  logic        reset;
  logic [31:0] rx_data;
  logic [3:0]  rx_datak;
  logic        rx_valid, rx_sync, offline_req, link_reset_req;
  state_t      state;
  logic        active, state_change;
  logic        clr;
`ifdef FC_PORT_STATE_STATS_EN
  logic [15:0] link_failures, link_recoveries;
`endif

  fc_port_state #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
    .rx_valid(rx_valid), .rx_sync(rx_sync), .offline_req(offline_req),
    .link_reset_req(link_reset_req),
`ifdef FC_PORT_STATE_STATS_EN
    .stats_clear(clr), .link_failures(link_failures), .link_recoveries(link_recoveries),
`endif
    .state(state), .active(active), .state_change(state_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  state_t trans [9][6];
  int     hist [$];
  state_t m_state;
  logic   m_sc, m_act;
  int     edge_n, entry_n;
  int     m_lf, m_rec;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  k;
    logic        v;
    state_t      exp;
    logic        sc;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int classify(input logic [31:0] w, input logic [3:0] k);
    if (k != 4'b1000) return K_NONE;
    if (w == OLS) return K_OLS;
    if (w == NOS) return K_NOS;
    if (w == LR) return K_LR;
    if (w == LRR) return K_LRR;
    if (w == IDLE || w == ARBFF) return K_IDLE;
    return K_NONE;
  endfunction

  task automatic init_trans();
    for (int s = 0; s < 9; s++)
      for (int k = 0; k < 6; k++) trans[s][k] = state_t'(s);
    trans[STATE_OL1][K_OLS] = STATE_OL2;  trans[STATE_OL1][K_LR]  = STATE_LR2;
    trans[STATE_OL2][K_LR]  = STATE_LR2;  trans[STATE_OL2][K_NOS] = STATE_LF1;
    trans[STATE_AC][K_LR]   = STATE_LR2;  trans[STATE_AC][K_LRR]  = STATE_LR3;
    trans[STATE_AC][K_OLS]  = STATE_OL2;  trans[STATE_AC][K_NOS]  = STATE_LF1;
    trans[STATE_LR1][K_LRR] = STATE_LR3;  trans[STATE_LR1][K_LR]  = STATE_LR2;
    trans[STATE_LR2][K_LRR] = STATE_LR3;  trans[STATE_LR2][K_IDLE] = STATE_AC;
    trans[STATE_LR3][K_IDLE] = STATE_AC;  trans[STATE_LR3][K_LR]  = STATE_LR2;
    trans[STATE_LF1][K_OLS] = STATE_OL2;  trans[STATE_LF1][K_LR]  = STATE_LR2;
    trans[STATE_LF2][K_NOS] = STATE_LF1;  trans[STATE_LF2][K_OLS] = STATE_OL2;
    trans[STATE_LF2][K_LR]  = STATE_LR2;
  endtask

  // Drive one cycle, advance the model, compare after the edge
  task automatic step(input logic [31:0] w, input logic [3:0] k, input logic v,
                      input logic s, input logic o, input logic l, input logic r);
    int kind;
    bit rec, to;
    state_t nxt, tgt;
    rx_data = w; rx_datak = k; rx_valid = v; rx_sync = s;
    offline_req = o; link_reset_req = l; reset = r;
    kind = classify(w, k);
    nxt = m_state;
    rec = 1'b0;
    if (r) begin
      hist.delete();
      nxt = STATE_OL1;
    end else begin
      if (!s) hist.delete();
      else if (v) begin
        if (kind == K_NONE) hist.delete();
        else begin
          hist.push_back(kind);
          if (hist.size() > 3) void'(hist.pop_front());
          rec = (hist.size() == 3) && (hist[0] == hist[1]) && (hist[1] == hist[2]);
        end
      end
      tgt = rec ? trans[int'(m_state)][kind] : m_state;
      to = (m_state inside {STATE_LR1, STATE_LR2, STATE_LR3}) && (edge_n - entry_n == int'(T));
      if (!s && !(m_state inside {STATE_OL1, STATE_OL2, STATE_OL3, STATE_LF2})) nxt = STATE_LF2;
      else if (o && m_state != STATE_OL3) nxt = STATE_OL3;
      else if (m_state == STATE_OL3 && !o) nxt = STATE_OL1;
      else if (tgt != m_state) nxt = tgt;
      else if (to) nxt = STATE_LF2;
      else if (l && m_state == STATE_AC) nxt = STATE_LR1;
    end
    m_sc  = !r && (nxt != m_state);
    m_act = !r && (nxt == STATE_AC);
    if (r || m_sc) entry_n = edge_n;
    if (r || clr) begin
      m_lf = 0; m_rec = 0;
    end else if (m_sc) begin
      if (nxt inside {STATE_LF1, STATE_LF2} && m_lf < 65535) m_lf++;
      if (nxt inside {STATE_LR1, STATE_LR2} && m_rec < 65535) m_rec++;
    end
    m_state = nxt;
    @(posedge clk);
    #1;
    edge_n++;
    check("model_state", 32'(state), 32'(m_state));
    check("model_active", 32'(active), 32'(m_act));
    check("model_state_change", 32'(state_change), 32'(m_sc));
`ifdef FC_PORT_STATE_STATS_EN
    check("model_link_failures", 32'(link_failures), 32'(m_lf));
    check("model_link_recoveries", 32'(link_recoveries), 32'(m_rec));
`endif
  endtask

  task automatic os3(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) step(w, 4'b1000, 1, 1, 0, 0, 0);
  endtask

  task automatic expect_state(input string name, input state_t exp);
    check(name, 32'(state), 32'(exp));
  endtask

  task automatic add(input logic [31:0] w, input logic [3:0] k, input logic v,
                     input state_t exp, input logic sc);
    vec_t e;
    e.w = w; e.k = k; e.v = v; e.exp = exp; e.sc = sc;
    tbl.push_back(e);
  endtask

  initial begin
    logic [31:0] rw;
    logic [3:0]  rk;
    logic        rs, ro;
    int          rem;
    init_trans();
    m_state = STATE_OL1; edge_n = 0; entry_n = 0; m_lf = 0; m_rec = 0;
    clr = 1'b0;
    rs = 1'b1; ro = 1'b0; rem = 0; rw = FILL; rk = 4'b0000;

    step(FILL, 4'b0000, 0, 1, 0, 0, 1);
    step(FILL, 4'b0000, 0, 1, 0, 0, 1);
    check("reset_state", 32'(state), 32'(STATE_OL1));
    check("reset_active", 32'(active), 32'd0);
    check("reset_state_change", 32'(state_change), 32'd0);

    // Bring-up, run breaking, gaps
    add(OLS, 4'b1000, 1, STATE_OL1, 0); add(OLS, 4'b1000, 1, STATE_OL1, 0);
    add(OLS, 4'b1000, 1, STATE_OL2, 1);
    add(LR, 4'b1000, 1, STATE_OL2, 0);  add(LR, 4'b1000, 1, STATE_OL2, 0);
    add(LR, 4'b1000, 1, STATE_LR2, 1);
    add(IDLE, 4'b1000, 1, STATE_LR2, 0); add(IDLE, 4'b1000, 1, STATE_LR2, 0);
    add(IDLE, 4'b1000, 1, STATE_AC, 1);
    add(LR, 4'b1000, 1, STATE_AC, 0);   add(LR, 4'b1000, 1, STATE_AC, 0);
    add(IDLE, 4'b1000, 1, STATE_AC, 0);
    add(LR, 4'b1000, 1, STATE_AC, 0);   add(LR, 4'b1000, 1, STATE_AC, 0);
    add(LR, 4'b1000, 1, STATE_LR2, 1);
    add(IDLE, 4'b1000, 1, STATE_LR2, 0); add(IDLE, 4'b1000, 1, STATE_LR2, 0);
    add(IDLE, 4'b1000, 1, STATE_AC, 1);
    add(LR, 4'b1000, 1, STATE_AC, 0);   add(GAPW, 4'b0000, 0, STATE_AC, 0);
    add(LR, 4'b1000, 1, STATE_AC, 0);   add(GAPW, 4'b0000, 0, STATE_AC, 0);
    add(LR, 4'b1000, 1, STATE_LR2, 1);
    add(ARBFF, 4'b1000, 1, STATE_LR2, 0); add(ARBFF, 4'b1000, 1, STATE_LR2, 0);
    add(ARBFF, 4'b1000, 1, STATE_AC, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].w, tbl[i].k, tbl[i].v, 1, 0, 0, 0);
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp));
      check($sformatf("tbl%0d_state_change", i), 32'(state_change), 32'(tbl[i].sc));
      check($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].exp == STATE_AC));
    end

    // Local link reset with no answer times out after T cycles
    step(FILL, 4'b0000, 1, 1, 0, 1, 0);
    expect_state("lrq_to_lr1", STATE_LR1);
    for (int i = 0; i < int'(T) - 1; i++) begin
      step(FILL, 4'b0000, 1, 1, 0, 0, 0);
      expect_state($sformatf("lr1_hold%0d", i), STATE_LR1);
    end
    step(FILL, 4'b0000, 1, 1, 0, 0, 0);
    expect_state("lr1_timeout_lf2", STATE_LF2);
    check("timeout_state_change", 32'(state_change), 32'd1);
    os3(LR, 3);   expect_state("lf2_lr_lr2", STATE_LR2);
    os3(IDLE, 3); expect_state("lr2_idle_ac", STATE_AC);

    // Answered link reset: LRR then ARBFF
    step(FILL, 4'b0000, 1, 1, 0, 1, 0);
    expect_state("lrq2_to_lr1", STATE_LR1);
    os3(LRR, 3);  expect_state("lr1_lrr_lr3", STATE_LR3);
    os3(ARBFF, 3); expect_state("lr3_arbff_ac", STATE_AC);
    check("ac_active", 32'(active), 32'd1);

    // Sync loss outranks offline, then offline takes over from LF2
    step(FILL, 4'b0000, 1, 0, 1, 0, 0); expect_state("prio_lf2", STATE_LF2);
    step(FILL, 4'b0000, 1, 0, 1, 0, 0); expect_state("prio_ol3", STATE_OL3);
    step(FILL, 4'b0000, 1, 0, 0, 0, 0); expect_state("ol3_release_ol1", STATE_OL1);
    os3(LR, 3); os3(IDLE, 3); expect_state("rebuild_ac", STATE_AC);

    // Sync loss alone, recover with NOS
    step(FILL, 4'b0000, 1, 0, 0, 0, 0); expect_state("sync_loss_lf2", STATE_LF2);
    step(NOS, 4'b1000, 1, 0, 0, 0, 0);  expect_state("lf2_no_sync_hold", STATE_LF2);
    os3(NOS, 2); expect_state("nos_two_hold", STATE_LF2);
    os3(NOS, 1); expect_state("lf2_nos_lf1", STATE_LF1);
    os3(LR, 3); os3(IDLE, 3); expect_state("rebuild_ac2", STATE_AC);

`ifdef FC_PORT_STATE_STATS_EN
    clr = 1'b1; step(FILL, 4'b0000, 1, 1, 0, 0, 0); clr = 1'b0;
    step(FILL, 4'b0000, 1, 0, 0, 0, 0);
    os3(NOS, 3); os3(LR, 3); os3(IDLE, 3);
    step(FILL, 4'b0000, 1, 1, 0, 1, 0);
    os3(LR, 3); os3(IDLE, 3);
    check("stats_failures_2", 32'(link_failures), 32'd2);
    check("stats_recoveries_3", 32'(link_recoveries), 32'd3);
    clr = 1'b1; step(FILL, 4'b0000, 1, 0, 0, 0, 0); clr = 1'b0;
    expect_state("stats_clear_lf2", STATE_LF2);
    check("stats_clear_failures", 32'(link_failures), 32'd0);
    check("stats_clear_recoveries", 32'(link_recoveries), 32'd0);
`endif

    // Random run against the model
    for (int n = 0; n < 3000; n++) begin
      if (rem == 0) begin
        rem = int'($urandom_range(1, 5));
        case ($urandom_range(0, 7))
          0: begin rw = IDLE;  rk = 4'b1000; end
          1: begin rw = ARBFF; rk = 4'b1000; end
          2: begin rw = OLS;   rk = 4'b1000; end
          3: begin rw = NOS;   rk = 4'b1000; end
          4: begin rw = LR;    rk = 4'b1000; end
          5: begin rw = LRR;   rk = 4'b1000; end
          6: begin rw = $urandom; rk = 4'b0000; end
          default: begin rw = 32'hBC12_3456; rk = 4'b1000; end
        endcase
      end
      if (rs) rs = ($urandom_range(0, 99) >= 2);
      else    rs = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 2) ro = ~ro;
`ifdef FC_PORT_STATE_STATS_EN
      clr = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 99) < 85) begin
        rem--;
        step(rw, rk, 1, rs, ro, ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) == 0));
      end else begin
        step(GAPW, 4'b1000, 0, rs, ro, ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) == 0));
      end
    end
    clr = 1'b0;

    step(LR, 4'b1000, 1, 1, 0, 0, 1);
    check("final_reset_state", 32'(state), 32'(STATE_OL1));
    check("final_reset_active", 32'(active), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_port_state.md
# fc_port_state

Fibre Channel port state controller for the framer. Watches received ordered sets and word-sync status, runs the FC-FS primary port state machine, and drives the `fc::state_t` value that selects which primitive sequence or fill word the transmit side sends. It also sequences link recovery and offline transitions and enforces the R_T_TOV receive-transmit timeout.

## Interface
- `TIMEOUT_CYCLES`, default 10_000_000: R_T_TOV in `clk` cycles. At 100 MHz this is 100 ms. Minimum value is 4.
- `clk`  in  1  Framer clock.
- `reset`  in  1  Synchronous, active-high reset.
- `rx_data`  in  32  Received word. The ordered set K28.5 is in byte 3.
- `rx_datak`  in  4  K flags for `rx_data`.
- `rx_valid`  in  1  A word is present on `rx_data`/`rx_datak` this cycle.
- `rx_sync`  in  1  Word synchronization acquired. 0 means loss of sync.
- `offline_req`  in  1  Level input. Software requests that the port go offline.
- `link_reset_req`  in  1  Single-cycle pulse. Request to initiate link recovery.
- `state`  out  `fc::state_t`  Current port state. Registered.
- `active`  out  1  High when `state == fc::STATE_AC`. Registered.
- `state_change`  out  1  Single-cycle pulse in the first cycle a new `state` value is visible.

## Operation
- **Ordered-set recognizer**
  - A word is an ordered set when `rx_datak == 4'b1000`.
  - It is classified as one of: OLS, NOS, LR, LRR, or IDLE. `fc::IDLE` and `fc::ARBFF` both count as IDLE.
  - Any other word clears the run.
  - A primitive sequence is recognized once 3 consecutive valid words carry the same ordered set. Recognition stays asserted while that ordered set keeps repeating.
  - A run counter saturates at 3. It is not advanced on cycles where `rx_valid == 0`; those cycles neither extend nor break the run.
  - The recognizer is cleared while `rx_sync == 0`.
- **Timer**
  - Counts up from 0 in states LR1, LR2 and LR3.
  - Cleared on every state change.
  - Fires when the count reaches `TIMEOUT_CYCLES-1`.
- **States and transitions.** Only the listed transitions occur; otherwise the state holds.
  - OL1: OLS → OL2. LR → LR2.
  - OL2: LR → LR2. NOS → LF1.
  - OL3: `offline_req == 0` → OL1.
  - AC: LR → LR2. LRR → LR3. OLS → OL2. NOS → LF1. `link_reset_req` → LR1.
  - LR1: LRR → LR3. LR → LR2. Timeout → LF2.
  - LR2: LRR → LR3. IDLE → AC. Timeout → LF2.
  - LR3: IDLE → AC. LR → LR2. Timeout → LF2.
  - LF1: OLS → OL2. LR → LR2.
  - LF2: NOS → LF1. OLS → OL2. LR → LR2.
- **Global transitions.** Priority, highest first:
  1. `reset` → OL1.
  2. `rx_sync == 0` in any state except OL1, OL2, OL3 or LF2 → LF2.
  3. `offline_req == 1` in any state except OL3 → OL3.
  4. Recognized sequence.
  5. Timeout.
  6. `link_reset_req`.
- **Ignored requests**
  - A `link_reset_req` in any state other than AC is dropped. It is not queued.
  - A `link_reset_req` that coincides with a recognized sequence in AC loses to the sequence.

## Timing
- Reset values: `state = fc::STATE_OL1`, `active = 0`, `state_change = 0`, run counter 0, timer 0.
- Sequence latency: `state` updates in the cycle after the clock edge that samples the 3rd matching valid word.
- Event latency: `rx_sync`, `offline_req` and `link_reset_req` each produce a state change 1 cycle after being sampled.
- Timeout: a state entered at cycle N with no other event leaves at cycle N+`TIMEOUT_CYCLES`.
- `active` and `state_change` change in the same cycle as `state`.
- Reset asserted mid-sequence or mid-timeout discards all progress. The first cycle after `reset` deasserts starts a fresh run count.
- A recognized sequence that persists across a state change is re-evaluated in the new state on the next cycle. Example: in AC with LR repeating, the port goes to LR2 and then holds there.

## Configuration
- `FC_PORT_STATE_STATS_EN`: when defined, adds these outputs:
  - `link_failures[15:0]`: increments on each entry to LF1 or LF2.
  - `link_recoveries[15:0]`: increments on each entry to LR1 or LR2.
  - `stats_clear` (input, 1 bit): clears both counters. It takes priority over an increment in the same cycle.
- Stats behaviour:
  - Both counters saturate at 16'hFFFF.
  - Both reset to 0.
- When the macro is not defined, these ports and counters do not exist, and state behaviour is identical.

## Test plan
- **Reset and bring-up:** after reset, send 3 OLS then 3 LR then 3 IDLE → state goes OL1 → OL2 → LR2 → AC. `active` rises 1 cycle after the 3rd IDLE, with a `state_change` pulse at each step.
- **Run breaking:** send LR, LR, IDLE, LR, LR, LR → only the final triple is recognized. No state change occurs before the 6th word.
- **Gaps do not break a run:** send LR, gap (`rx_valid == 0`), LR, gap, LR → recognized.
- **Local link reset:** in AC, pulse `link_reset_req` → LR1. With no response, the port reaches LF2 exactly `TIMEOUT_CYCLES` (4 in the bench) cycles later. Repeat, answering with 3 LRR → LR3, then 3 ARBFF → AC.
- **Priority:** in AC, deassert `rx_sync` and assert `offline_req` in the same cycle → OL3, then OL1 after `offline_req` drops.
  - Repeat with only `rx_sync == 0` → LF2. With sync restored, 3 NOS → LF1.
- **Stats** (with `FC_PORT_STATE_STATS_EN`): force 2 link failures and 3 link recoveries → `link_failures == 2`, `link_recoveries == 3`.
  - `stats_clear` asserted in the same cycle as an increment → counters read 0.
